// File: rtl/tx_msg_scheduler_pkg.sv
// tx_msg_scheduler_pkg: FSM states, fixed message ROM and per-id lengths.
package tx_msg_scheduler_pkg;
   localparam int NUM_REQ = 4;
   localparam int ROM_W   = 8;
   typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;
   localparam logic [7:0] MSG_ROM [NUM_REQ][ROM_W] = '{
      '{8'h50, 8'h4F, 8'h4C, 8'h4F, 8'h0D, 8'h0A, 8'h00, 8'h00},
      '{8'h41, 8'h43, 8'h4B, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00},
      '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00},
      '{8'h52, 8'h45, 8'h41, 8'h44, 8'h59, 8'h0D, 8'h0A, 8'h00}
   };
   localparam logic [2:0] MSG_LEN [NUM_REQ] = '{3'd6, 3'd5, 3'd5, 3'd7};
endpackage

// File: rtl/tx_msg_scheduler_rr_arbiter4.sv
// rr_arbiter4: combinational round-robin pick, searching from last grant + 1.
module rr_arbiter4
   import tx_msg_scheduler_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [1:0]         i_last,
   output logic               o_valid,
   output logic [1:0]         o_id
);
   logic [1:0] w_cand;
   // Descending scan so the nearest candidate after i_last overwrites the rest.
   always_comb begin
      o_valid = 1'b0;
      o_id    = i_last;
      w_cand  = i_last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_cand = i_last + 2'(k);
         if (i_req[w_cand]) begin
            o_valid = 1'b1;
            o_id    = w_cand;
         end
      end
   end
endmodule

// File: rtl/tx_msg_scheduler.sv
// tx_msg_scheduler: queues per-requester fixed messages and streams them byte-wise to a UART.
module tx_msg_scheduler
   import tx_msg_scheduler_pkg::*;
#(
   parameter int TIMEOUT = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic [3:0] pending,
   output logic       active,
   output logic [1:0] grant_id,
   output logic       done,
   output logic       error,
   output logic [7:0] drop_cnt
);
   localparam int TW = $clog2(TIMEOUT + 1);
   state_t        r_state;
   logic [3:0]    r_req;
   logic [3:0]    r_pending;
   logic [1:0]    r_last;
   logic [1:0]    r_grant;
   logic [2:0]    r_idx;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_tx_data;
   logic [7:0]    r_drop;
   logic          r_tx_start;
   logic          r_done;
   logic          r_error;
   logic          w_gv;
   logic [1:0]    w_gid;
   logic [3:0]    w_clr;
   logic [3:0]    w_drop;
   logic [8:0]    w_drop_sum;

   rr_arbiter4 u_arb (
      .i_req   (r_pending),
      .i_last  (r_last),
      .o_valid (w_gv),
      .o_id    (w_gid)
   );

   // A request landing on the bit being granted re-arms it instead of counting as a drop.
   assign w_clr      = (r_state == IDLE && w_gv) ? (4'b0001 << w_gid) : 4'd0;
   assign w_drop     = r_req & r_pending & ~w_clr;
   assign w_drop_sum = 9'(r_drop) + 9'($countones(w_drop));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_req      <= 4'd0;
         r_pending  <= 4'd0;
         r_last     <= 2'd3;
         r_grant    <= 2'd0;
         r_idx      <= 3'd0;
         r_tmo      <= '0;
         r_tx_data  <= 8'h00;
         r_drop     <= 8'd0;
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_req      <= req;
         r_pending  <= (r_pending & ~w_clr) | r_req;
         r_drop     <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         case (r_state)
            IDLE: if (w_gv) begin
               r_grant <= w_gid;
               r_last  <= w_gid;
               r_idx   <= 3'd0;
               r_state <= SEND;
            end
            SEND: if (!tx_busy) begin
               r_tx_start <= 1'b1;
               r_tx_data  <= MSG_ROM[r_grant][r_idx];
               r_tmo      <= '0;
               r_state    <= WAIT_HI;
            end
            WAIT_HI: if (tx_busy) begin
               r_state <= WAIT_LO;
            end else if (r_tmo == TW'(TIMEOUT - 1)) begin
               r_error <= 1'b1;
               r_state <= IDLE;
            end else begin
               r_tmo <= r_tmo + TW'(1);
            end
            WAIT_LO: if (!tx_busy) begin
               if (r_idx == MSG_LEN[r_grant] - 3'd1) begin
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= SEND;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign pending  = r_pending;
   assign active   = (r_state != IDLE);
   assign grant_id = r_grant;
   assign done     = r_done;
   assign error    = r_error;
   assign drop_cnt = r_drop;
endmodule

// File: tb/tb_tx_msg_scheduler.sv
// tb_tx_msg_scheduler: randomized scoreboard bench against a message-level reference model.
module tb_tx_msg_scheduler;
   localparam int TIMEOUT = 16;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'd0;
   logic       xb = 1'b0;
   logic       hb = 1'b0;
   logic       tx_busy;
   logic [7:0] tx_data;
   logic       tx_start;
   logic [3:0] pending;
   logic       active;
   logic [1:0] grant_id;
   logic       done;
   logic       error;
   logic [7:0] drop_cnt;

   assign tx_busy = xb | hb;

   tx_msg_scheduler #(.TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .tx_busy  (tx_busy),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .pending  (pending),
      .active   (active),
      .grant_id (grant_id),
      .done     (done),
      .error    (error),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   tx_cnt = 0;
   int   done_cnt = 0;
   int   last_start = 0;
   int   busy_len = 10;
   bit   mute = 1'b0;
   logic prev_busy = 1'b0;
   logic [7:0] exp_b [$];
   int   exp_done [$];
   int   exp_err [$];
   logic [3:0] m_pend = 4'd0;
   int   m_last = 3;
   int   m_drop = 0;
   string msgs [4] = '{"POLO\015\012", "ACK\015\012", "ERR\015\012", "READY\015\012"};

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: DUT output with nothing expected", name);
   endtask

   // Reference model: pending set drained in round-robin order, one whole message per grant.
   task automatic plan(input logic [3:0] m);
      int id;
      id = 0;
      m_pend |= m;
      while (m_pend != 4'd0) begin
         for (int k = 1; k <= 4; k++) begin
            id = (m_last + k) % 4;
            if (m_pend[id]) break;
         end
         m_pend[id] = 1'b0;
         m_last = id;
         if (mute) begin
            exp_b.push_back(msgs[id][0]);
            exp_err.push_back(id);
         end else begin
            for (int i = 0; i < msgs[id].len(); i++) exp_b.push_back(msgs[id][i]);
            exp_done.push_back(id);
         end
      end
   endtask

   task automatic pulse(input logic [3:0] m);
      @(negedge clk); req = m;
      @(negedge clk); req = 4'd0;
   endtask

   task automatic set_hb(input logic v);
      @(posedge clk); #2 hb = v;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_b.size() != 0 || exp_done.size() != 0 || exp_err.size() != 0 || active) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(n < 5000), 1);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1; xb = 1'b0;
      exp_b.delete(); exp_done.delete(); exp_err.delete();
      m_pend = 4'd0; m_last = 3; m_drop = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Transmitter model: raise busy shortly after each start strobe, hold for busy_len edges.
   initial forever begin
      @(posedge clk); #2;
      if (tx_start && !mute) begin
         xb = 1'b1;
         repeat (busy_len) @(posedge clk);
         #2 xb = 1'b0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (tx_start) begin
            tx_cnt++;
            last_start = cyc;
            chk("start_while_busy", int'(prev_busy), 0);
            if (exp_b.size() == 0) fail("tx_start");
            else chk("tx_data", int'(tx_data), int'(exp_b.pop_front()));
         end
         if (done) begin
            done_cnt++;
            if (exp_done.size() == 0) fail("done");
            else chk("done_grant_id", int'(grant_id), exp_done.pop_front());
         end
         if (error) begin
            if (exp_err.size() == 0) fail("error");
            else begin
               void'(exp_err.pop_front());
               chk("error_delay", cyc - last_start, TIMEOUT);
               chk("error_active", int'(active), 0);
            end
         end
      end
      prev_busy = tx_busy;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int e;
      int base;
      int dbase;
      int n;
      logic [3:0] m;
      repeat (3) @(negedge clk);
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_grant_id", int'(grant_id), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_done_error", int'({done, error}), 0);
      chk("rst_drop_cnt", int'(drop_cnt), 0);
      rst = 1'b0;

      // single request with latency
      busy_len = 10;
      base = tx_cnt; dbase = done_cnt;
      plan(4'b0001);
      @(negedge clk); req = 4'b0001; e = cyc + 1;
      @(negedge clk); req = 4'd0;
      @(negedge clk); chk("lat_pending", int'(pending), 1);
      @(negedge clk); chk("lat_grant", int'({active, grant_id}), 4);
      @(negedge clk); chk("lat_start", int'(tx_start), 1);
      chk("lat_cycle", cyc, e + 3);
      drain("drain_single");
      chk("single_tx_count", tx_cnt - base, 6);
      chk("single_done_count", done_cnt - dbase, 1);
      chk("grant_hold_idle", int'(grant_id), 0);

      // contention from reset
      do_reset();
      busy_len = 3;
      base = tx_cnt; dbase = done_cnt;
      plan(4'b1111);
      pulse(4'b1111);
      @(negedge clk); chk("cont_pending", int'(pending), 15);
      drain("drain_contention");
      chk("cont_tx_count", tx_cnt - base, 23);
      chk("cont_done_count", done_cnt - dbase, 4);
      chk("cont_pending_end", int'(pending), 0);

      // randomized single-cycle request masks
      for (int it = 0; it < 20; it++) begin
         busy_len = $urandom_range(1, 6);
         m = 4'($urandom_range(1, 15));
         plan(m);
         pulse(m);
         drain("drain_random");
         chk("rand_pending_end", int'(pending), 0);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end

      // request held across its own grant cycle
      busy_len = 2;
      plan(4'b0100);
      plan(4'b0100);
      @(negedge clk); req = 4'b0100;
      @(negedge clk);
      @(negedge clk); req = 4'd0;
      drain("drain_same_cycle");
      chk("same_cycle_drop", int'(drop_cnt), m_drop);

      // busy held at request, then drops while id1 waits
      set_hb(1'b1);
      base = tx_cnt;
      plan(4'b0100);
      pulse(4'b0100);
      repeat (20) @(negedge clk);
      chk("hold_no_start", tx_cnt - base, 0);
      chk("hold_active", int'(active), 1);
      plan(4'b0010);
      pulse(4'b0010);
      repeat (2) @(negedge clk);
      chk("hold_pending", int'(pending), 2);
      for (int i = 0; i < 300; i++) begin
         pulse(4'b0010);
         m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end
      repeat (3) @(negedge clk);
      chk("drop_saturated", int'(drop_cnt), m_drop);
      chk("drop_pending", int'(pending), 2);
      set_hb(1'b0);
      drain("drain_drops");

      // transmitter never goes busy
      mute = 1'b1;
      dbase = done_cnt;
      plan(4'b1000);
      pulse(4'b1000);
      drain("drain_timeout");
      chk("timeout_no_done", done_cnt - dbase, 0);
      mute = 1'b0;
      repeat (3) @(negedge clk);

      // reset in the middle of id3
      busy_len = 4;
      base = tx_cnt;
      plan(4'b1000);
      pulse(4'b1000);
      n = 0;
      while (tx_cnt - base < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_byte3", int'(n < 2000), 1);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx_start", int'(tx_start), 0);
      chk("mid_rst_tx_data", int'(tx_data), 0);
      chk("mid_rst_active", int'(active), 0);
      chk("mid_rst_grant_id", int'(grant_id), 0);
      chk("mid_rst_flags", int'({done, error, pending}), 0);
      chk("mid_rst_drop_cnt", int'(drop_cnt), 0);
      exp_b.delete(); exp_done.delete(); exp_err.delete();
      m_pend = 4'd0; m_last = 3; m_drop = 0;
      xb = 1'b0;
      @(negedge clk); rst = 1'b0;
      base = tx_cnt;
      repeat (40) @(negedge clk);
      chk("post_rst_quiet", tx_cnt - base, 0);
      chk("post_rst_idle", int'(active), 0);
      plan(4'b1010);
      pulse(4'b1010);
      drain("drain_post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tx_msg_scheduler.md
TX_MSG_SCHEDULER -- requirements
Module: tx_msg_scheduler

Interface
REQ-001 The block SHALL have exactly one parameter: TIMEOUT, default 16, the cycles allowed for tx_busy to rise after tx_start.
REQ-002 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  4  per-requester message request; a 1 in any sampled cycle SHALL queue that requester's message.
REQ-005 tx_busy  in  1  busy flag from the UART byte transmitter.
REQ-006 tx_data  out  8  byte presented to the transmitter; valid while tx_start is 1.
REQ-007 tx_start  out  1  one-cycle send strobe to the transmitter.
REQ-008 pending  out  4  queued-but-not-granted requests.
REQ-009 active  out  1  a message is in progress; 1 in every state except IDLE.
REQ-010 grant_id  out  2  requester currently being served; holds its last value while IDLE.
REQ-011 done  out  1  one-cycle pulse after the last byte of a message completes.
REQ-012 error  out  1  one-cycle pulse when a message is aborted on timeout.
REQ-013 drop_cnt  out  8  saturating count of requests discarded because that requester's request was already pending.

Function
REQ-014 Fixed messages SHALL be:
- id0 = "POLO\r\n" (50 4F 4C 4F 0D 0A, length 6).
- id1 = "ACK\r\n" (41 43 4B 0D 0A, length 5).
- id2 = "ERR\r\n" (45 52 52 0D 0A, length 5).
- id3 = "READY\r\n" (52 45 41 44 59 0D 0A, length 7).
REQ-015 req[i]=1 SHALL set pending[i] on the next edge; if pending[i] is already 1, drop_cnt SHALL increment, saturating at 255.
REQ-016 The FSM SHALL have the states IDLE, SEND, WAIT_HI and WAIT_LO.
REQ-017 In IDLE with pending nonzero, the block SHALL:
- grant round-robin, searching from (last grant + 1) mod 4;
- latch grant_id, clear pending[grant], reset the byte index to 0;
- go to SEND.
REQ-018 If req[g] is asserted in the same cycle that g is granted, the set SHALL win: pending[g] stays 1 and drop_cnt is unchanged.
REQ-019 In SEND with tx_busy=0, the block SHALL register tx_start=1 and tx_data=message byte[index] for exactly one cycle and go to WAIT_HI; with tx_busy=1 it SHALL stay in SEND.
REQ-020 In WAIT_HI:
- tx_busy=1 -> WAIT_LO;
- TIMEOUT cycles with tx_busy=0 -> error pulse, return to IDLE, remaining bytes discarded, no done pulse.
REQ-021 In WAIT_LO, on tx_busy=0:
- if index = length-1: done pulse, go to IDLE;
- otherwise: increment index, go to SEND.
REQ-022 Byte index SHALL be 3 bits and SHALL never exceed length-1 of the granted message.
REQ-023 Latency: req sampled at edge E -> pending at E+1 -> grant at E+2 -> tx_start high in the cycle after E+3, provided the block is idle and tx_busy=0.
REQ-024 Messages SHALL never interleave; a grant SHALL occur only from IDLE.
REQ-025 tx_start SHALL never be asserted while tx_busy=1.

Reset
REQ-026 rst=1 SHALL asynchronously set:
- FSM state IDLE;
- pending=0, index=0, timeout counter=0;
- round-robin pointer such that id0 wins first;
- tx_start=0, tx_data=0x00, active=0, grant_id=0, done=0, error=0, drop_cnt=0.
REQ-027 Reset asserted mid-message SHALL abandon the message with no done or error pulse; after release, the block SHALL wait for a new req.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the message byte table, the per-id message lengths and NUM_REQ=4.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter4 (inputs: request vector, last grant; outputs: grant valid, grant id), purely combinational.

Verification
REQ-030 Single request: pulse req=0001; model transmitter with busy high 10 cycles per byte -> bytes 50 4F 4C 4F 0D 0A in order, exactly 6 tx_start pulses, one done, grant_id=0.
REQ-031 Contention: req=1111 in one cycle after reset -> messages served in order id0, id1, id2, id3, 4 done pulses, 23 tx_start pulses total, pending=0000 at end.
REQ-032 Drops and saturation: while id1 is pending, pulse req[1] 300 times -> drop_cnt=255 and only one id1 message is sent.
REQ-033 Timeout: transmitter never raises busy -> tx_start, then after 16 cycles error=1 for one cycle, active=0, no done.
REQ-034 Reset mid-message: assert rst during byte 3 of id3 -> all outputs go to reset values immediately, no further tx_start after release until a new req.
REQ-035 Busy at request: tx_busy=1 held when req=0100 -> no tx_start until tx_busy falls; the first byte is then 45.
